// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues load/store transactions on a req/gnt/rvalid
// bus, aligns byte/halfword lanes and presents a registered writeback bundle.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        valid_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_en,
  output logic        misaligned,
  output logic        bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10} size_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  tmo_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        valid_q, mis_q, berr_q, wb_en_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;

  logic        mem_op, misal_d, tmo_hit;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, load_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign mem_op  = is_load | is_store;
  assign tmo_hit = (tmo_q >= TMO_LAST);

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    misal_d = 1'b0;
    be_d    = 4'b1111;
    wdata_d = store_data;
    case (funct3[1:0])
      SZ_BYTE: begin
        be_d    = 4'b0001 << alu_result[1:0];
        wdata_d = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        misal_d = alu_result[0];
        be_d    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{store_data[15:0]}};
      end
      default: misal_d = (alu_result[1:0] != 2'b00);
    endcase
  end

  // Lane extraction uses the address bits latched at accept time.
  always_comb begin
    ld_byte = dmem_rdata[8*off_q +: 8];
    ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      SZ_BYTE: load_d = uns_q ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: load_d = uns_q ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: load_d = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tmo_q     <= '0;
      off_q     <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rd_q      <= '0;
      rw_q      <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      berr_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_data_q <= '0;
      wb_rd_q   <= '0;
    end else begin
      // NOTE: non-blocking defaults here make valid/misaligned/bus_err single-cycle pulses.
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in && !mem_op) begin
            valid_q   <= 1'b1;
            wb_data_q <= alu_result;
            wb_rd_q   <= rd;
            wb_en_q   <= reg_write;
          end else if (valid_in && misal_d) begin
            valid_q <= 1'b1;
            mis_q   <= 1'b1;
            wb_en_q <= 1'b0;
          end else if (valid_in) begin
            state_q <= REQ;
            tmo_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= is_store & ~is_load;
            addr_q  <= {alu_result[31:2], 2'b00};
            be_q    <= be_d;
            wdata_q <= wdata_d;
            off_q   <= alu_result[1:0];
            size_q  <= funct3[1:0];
            uns_q   <= funct3[2];
            rd_q    <= rd;
            rw_q    <= reg_write;
          end
        end
        REQ: begin
          tmo_q <= tmo_q + 8'd1;
          if (dmem_gnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              state_q <= IDLE;
              valid_q <= 1'b1;
              wb_en_q <= 1'b0;
            end else begin
              state_q <= RESP;
            end
          end else if (tmo_hit) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
            valid_q <= 1'b1;
            berr_q  <= 1'b1;
            wb_en_q <= 1'b0;
          end
        end
        RESP: begin
          tmo_q <= tmo_q + 8'd1;
          if (dmem_rvalid) begin
            state_q   <= IDLE;
            valid_q   <= 1'b1;
            wb_data_q <= load_d;
            wb_rd_q   <= rd_q;
            wb_en_q   <= rw_q;
          end else if (tmo_hit) begin
            state_q <= IDLE;
            valid_q <= 1'b1;
            berr_q  <= 1'b1;
            wb_en_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = (state_q != IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign valid_out  = valid_q;
  assign wb_data    = wb_data_q;
  assign wb_rd      = wb_rd_q;
  assign wb_en      = wb_en_q;
  assign misaligned = mis_q;
  assign bus_err    = berr_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writeback bundles are queued at issue
// and compared whenever valid_out is seen; bus-side behaviour is checked inline.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] alu_result, store_data;
  logic        is_load, is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        reg_write;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        valid_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_en, misaligned, bus_err;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        en;
    logic        mis;
    logic        berr;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result(alu_result),
    .store_data(store_data), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .rd(rd), .reg_write(reg_write), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .valid_out(valid_out),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_en(wb_en),
    .misaligned(misaligned), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r, input logic rw);
    valid_in   = 1'b1;
    is_load    = ld;
    is_store   = st;
    funct3     = f3;
    alu_result = a;
    store_data = sd;
    rd         = r;
    reg_write  = rw;
  endtask

  task automatic push(input logic [31:0] d, input logic [4:0] r, input logic en,
                      input logic mis, input logic berr, input logic cd);
    exp_t e;
    e.data = d; e.rd = r; e.en = en; e.mis = mis; e.berr = berr; e.chk_data = cd;
    sb.push_back(e);
  endtask

  // Output monitor: every valid_out pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 32'(valid_out), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_en", 32'(wb_en), 32'(e.en));
        check("misaligned", 32'(misaligned), 32'(e.mis));
        check("bus_err", 32'(bus_err), 32'(e.berr));
        if (e.chk_data) begin
          check("wb_data", wb_data, e.data);
          check("wb_rd", 32'(wb_rd), 32'(e.rd));
        end
      end
    end
  end

  initial begin
    logic [31:0] rdat;
    logic [2:0]  ld_f3  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] ld_exp [3] = '{32'hFFFF_FF81, 32'h0000_007F, 32'hFFFF_80F0};

    rst = 1'b1; valid_in = 1'b0; alu_result = '0; store_data = '0;
    is_load = 1'b0; is_store = 1'b0; funct3 = '0; rd = '0; reg_write = 1'b0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    tick(); tick();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_dmem_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst = 1'b0;

    // ALU pass-through, back to back
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 3'b000, 32'h11 * (i + 1), 32'd0, 5'(i + 1), 1'b1);
      push(32'h11 * (i + 1), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      check("alu_stall", 32'(stall), 32'd0);
    end
    valid_in = 1'b0;
    tick();
    check("alu_drained", sb.size(), 32'd0);

    // Store byte at 0x1003, grant on the third request cycle
    drive(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 5'd9, 1'b0);
    push(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("sb_req", 32'(dmem_req), 32'd1);
      check("sb_we", 32'(dmem_we), 32'd1);
      check("sb_addr", dmem_addr, 32'h0000_1000);
      check("sb_be", 32'(dmem_be), 32'b1000);
      check("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      check("sb_stall", 32'(stall), 32'd1);
      dmem_gnt = (k == 2);
      tick();
    end
    dmem_gnt = 1'b0;
    check("sb_req_drop", 32'(dmem_req), 32'd0);
    check("sb_stall_end", 32'(stall), 32'd0);
    tick();

    // Loads LB / LBU / LH from a single data word
    rdat = 32'h80F0_7F81;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, ld_f3[i], 32'h0000_3000 + 32'(i), 32'd0, 5'(10 + i), 1'b1);
      push(ld_exp[i], 5'(10 + i), 1'b1, 1'b0, 1'b0, 1'b1);
      tick();
      valid_in = 1'b0;
      check("ld_stall_req", 32'(stall), 32'd1);
      check("ld_req", 32'(dmem_req), 32'd1);
      check("ld_we", 32'(dmem_we), 32'd0);
      check("ld_addr", dmem_addr, 32'h0000_3000);
      dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      check("ld_stall_resp", 32'(stall), 32'd1);
      check("ld_req_resp", 32'(dmem_req), 32'd0);
      dmem_rvalid = 1'b1;
      dmem_rdata  = rdat;
      tick();
      dmem_rvalid = 1'b0;
      dmem_rdata  = '0;
      check("ld_stall_done", 32'(stall), 32'd0);
    end
    tick();

    // Misaligned word load: no bus request at all
    drive(1'b1, 1'b0, 3'b010, 32'h0000_2002, 32'd0, 5'd5, 1'b1);
    push(32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("mis_no_req", 32'(dmem_req), 32'd0);
      check("mis_stall", 32'(stall), 32'd0);
      tick();
    end

    // Timeout with no grant: request held exactly four cycles
    drive(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 5'd6, 1'b1);
    push(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("to_req_held", 32'(dmem_req), 32'd1);
      tick();
    end
    check("to_req_drop", 32'(dmem_req), 32'd0);
    check("to_stall", 32'(stall), 32'd0);
    tick();

    // Grant arrives on the fourth request cycle: completes normally
    drive(1'b1, 1'b0, 3'b010, 32'h0000_4004, 32'd0, 5'd7, 1'b1);
    push(32'hCAFE_F00D, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    valid_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("tg_req_held", 32'(dmem_req), 32'd1);
      dmem_gnt = (k == 3);
      tick();
    end
    dmem_gnt = 1'b0;
    check("tg_req_drop", 32'(dmem_req), 32'd0);
    check("tg_stall_resp", 32'(stall), 32'd1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    tick();

    // Reset while waiting for read data; a late rvalid must be ignored
    drive(1'b1, 1'b0, 3'b010, 32'h0000_5008, 32'd0, 5'd8, 1'b1);
    tick();
    valid_in = 1'b0;
    dmem_gnt = 1'b1;
    tick();
    dmem_gnt = 1'b0;
    check("rm_in_resp", 32'(stall), 32'd1);
    rst = 1'b1;
    tick();
    check("rm_stall", 32'(stall), 32'd0);
    check("rm_req", 32'(dmem_req), 32'd0);
    check("rm_valid", 32'(valid_out), 32'd0);
    check("rm_wb_data", wb_data, 32'd0);
    check("rm_wb_rd", 32'(wb_rd), 32'd0);
    check("rm_wb_en", 32'(wb_en), 32'd0);
    check("rm_addr", dmem_addr, 32'd0);
    check("rm_be", 32'(dmem_be), 32'd0);
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    tick();
    dmem_rvalid = 1'b0;
    check("rm_late_rvalid", 32'(valid_out), 32'd0);
    tick(); tick();

    check("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
